// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch return path.
//   NOP_INSTR   : instruction presented whenever nothing valid is available
//   LINE_TAG_W  : width of an 8-byte line address (pc[31:3])
//   fa_state_e  : crossing-merge FSM states
//   line_t      : one SRAM line with its tag
package core_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0
  localparam int          LINE_TAG_W = 29;
  localparam int          LINE_BITS  = 64;

  typedef logic [LINE_TAG_W-1:0] line_tag_t;

  typedef enum logic {
    IDLE       = 1'b0,
    CROSS_WAIT = 1'b1
  } fa_state_e;

  typedef struct packed {
    line_tag_t            tag;
    logic [LINE_BITS-1:0] data;
  } line_t;

endpackage

// File: rtl/ifu_fetch_align_if.sv
// SRAM read-return bus into the fetch aligner.
//   isram_rvalid : line data valid this cycle (registered isram_cs)
//   isram_rtag   : line address [31:3] of the returned data
//   isram_rdata  : returned 64-bit line, halfword k = rdata[16k+15:16k]
// master = SRAM return side (drives), slave = aligner (receives).
interface ifu_fetch_align_if;
  import core_pkg::*;

  logic                 isram_rvalid;
  line_tag_t            isram_rtag;
  logic [LINE_BITS-1:0] isram_rdata;

  modport master (output isram_rvalid, isram_rtag, isram_rdata);
  modport slave  (input  isram_rvalid, isram_rtag, isram_rdata);
endinterface

// File: rtl/ifu_line_buf.sv
// Single-entry line buffer: valid bit + tag + 64-bit line.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : capture line_i and set valid
//   inv_i       : clear valid (wins over load_i)
//   line_i      : line/tag to capture
//   vld_o       : buffer holds a line
//   line_o      : buffered line/tag
module ifu_line_buf
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  inv_i,
  input  line_t line_i,
  output logic  vld_o,
  output line_t line_o
);

  logic  vld_q,  vld_d;
  line_t line_q, line_d;

  always_comb begin
    vld_d  = vld_q;
    line_d = line_q;
    if (inv_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d  = 1'b1;
      line_d = line_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      line_q <= '0;
    end else begin
      vld_q  <= vld_d;
      line_q <= line_d;
    end
  end

  assign vld_o  = vld_q;
  assign line_o = line_q;

endmodule

// File: rtl/ifu_fetch_align.sv
// Fetch return-side aligner. Picks the 16/32-bit instruction at pc out of
// the line returned by the instruction SRAM (or the buffered copy of the
// last line) and merges the halves of a 32-bit instruction that straddles
// two 8-byte lines.
// Build option: IFU_FETCH_ALIGN_RVC_EN enables compressed-instruction
// alignment (pc[1] honoured, isrv16 live, crossing FSM present). Without it
// pc[1] is ignored and every instruction is a full aligned word.
// Ports:
//   clk, cpurst_n      : clock, asynchronous active-low reset
//   bus (slave)        : SRAM return (isram_rvalid/rtag/rdata)
//   pc                 : current fetch PC
//   fet_stall          : pipeline stall, pc held upstream
//   fet_flush          : redirect, drops pending state
//   branch_predict_err : mispredict, drops buffer and pending state
//   rv32_instr         : instruction at pc, NOP_INSTR when invalid
//   isrv16             : instruction is 16-bit (and valid)
//   instr_valid        : rv32_instr is the complete instruction at pc
//   fetch_misalign     : instruction at pc unavailable (= !instr_valid)
module ifu_fetch_align #(
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR,
  parameter int          LINE_W    = 64
) (
  input  logic               clk,
  input  logic               cpurst_n,
  ifu_fetch_align_if.slave   bus,
  input  logic [31:0]        pc,
  input  logic               fet_stall,
  input  logic               fet_flush,
  input  logic               branch_predict_err,
  output logic [31:0]        rv32_instr,
  output logic               isrv16,
  output logic               instr_valid,
  output logic               fetch_misalign
);
  import core_pkg::*;

  // Any redirect kills this cycle's return data and all pending state.
  logic kill;
  assign kill = fet_flush | branch_predict_err;

  // ---------------------------------------------------------------------------
  // Line source: live SRAM return bypasses the buffer.
  // ---------------------------------------------------------------------------
  line_t rd_line, buf_line, src_line;
  logic  buf_vld, src_vld, hit;

  assign rd_line = '{tag: bus.isram_rtag, data: bus.isram_rdata};

  ifu_line_buf u_line_buf (
    .clk    (clk),
    .rst_n  (cpurst_n),
    .load_i (bus.isram_rvalid & ~kill),
    .inv_i  (kill),
    .line_i (rd_line),
    .vld_o  (buf_vld),
    .line_o (buf_line)
  );

  assign src_line = bus.isram_rvalid ? rd_line : buf_line;
  assign src_vld  = ~kill & (bus.isram_rvalid | buf_vld);
  assign hit      = src_vld && (src_line.tag == pc[31:3]);

  logic [3:0][15:0] src_hw;
  assign src_hw = src_line.data[LINE_W-1:0];

  logic [31:0] instr;
  logic        vld;

`ifdef IFU_FETCH_ALIGN_RVC_EN
  // ---------------------------------------------------------------------------
  // Compressed-aware extraction with line-crossing merge.
  // ---------------------------------------------------------------------------
  fa_state_e state_q, state_d;
  logic [15:0] hold_hw_q, hold_hw_d;
  line_tag_t   hold_tag_q, hold_tag_d;

  logic [1:0]  idx;
  logic [15:0] hw;
  logic        pc_at_hold, next_line_hit;

  assign idx = pc[2:1];
  assign hw  = src_hw[idx];

  // pc still addresses the upper halfword of the held line.
  assign pc_at_hold    = (pc[31:1] == {hold_tag_q, 2'b11});
  // Sequential line, tag wrapping naturally at 2^29.
  assign next_line_hit = src_vld && (src_line.tag == hold_tag_q + line_tag_t'(1));

  always_comb begin
    state_d    = state_q;
    hold_hw_d  = hold_hw_q;
    hold_tag_d = hold_tag_q;
    vld        = 1'b0;
    instr      = NOP_INSTR;
    if (kill) begin
      state_d    = IDLE;
      hold_hw_d  = '0;
      hold_tag_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (hw[1:0] != 2'b11) begin
              vld   = 1'b1;
              instr = {16'h0000, hw};
            end else if (idx != 2'd3) begin
              vld   = 1'b1;
              instr = {src_hw[idx + 2'd1], hw};
            end else begin
              // Upper half lives in the next line; park the lower half.
              hold_hw_d  = hw;
              hold_tag_d = pc[31:3];
              state_d    = CROSS_WAIT;
            end
          end
        end
        CROSS_WAIT: begin
          if (!pc_at_hold) begin
            state_d = IDLE;
          end else if (next_line_hit) begin
            vld   = 1'b1;
            instr = {src_hw[0], hold_hw_q};
            // Keep presenting the merged word while decode is stalled.
            if (!fet_stall) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_q    <= IDLE;
      hold_hw_q  <= '0;
      hold_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_hw_q  <= hold_hw_d;
      hold_tag_q <= hold_tag_d;
    end
  end

  logic unused_pc;
  assign unused_pc = pc[0];

  assign isrv16 = vld & (instr[1:0] != 2'b11);
`else
  // ---------------------------------------------------------------------------
  // Word-only extraction: pc[1] ignored, no crossing possible.
  // ---------------------------------------------------------------------------
  always_comb begin
    vld   = 1'b0;
    instr = NOP_INSTR;
    if (hit) begin
      vld   = 1'b1;
      instr = {src_hw[{pc[2], 1'b1}], src_hw[{pc[2], 1'b0}]};
    end
  end

  logic [1:0] unused_pc;
  assign unused_pc = pc[1:0];

  assign isrv16 = 1'b0;
`endif

  assign rv32_instr     = instr;
  assign instr_valid    = vld;
  assign fetch_misalign = ~vld;

endmodule

// File: tb/tb_ifu_fetch_align.sv
module tb_ifu_fetch_align;

  logic        clk = 1'b0;
  logic        cpurst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        fet_stall = 1'b0, fet_flush = 1'b0, branch_predict_err = 1'b0;
  logic [31:0] rv32_instr;
  logic        isrv16, instr_valid, fetch_misalign;

  ifu_fetch_align_if sram_if ();

  ifu_fetch_align dut (
    .clk                (clk),
    .cpurst_n           (cpurst_n),
    .bus                (sram_if),
    .pc                 (pc),
    .fet_stall          (fet_stall),
    .fet_flush          (fet_flush),
    .branch_predict_err (branch_predict_err),
    .rv32_instr         (rv32_instr),
    .isrv16             (isrv16),
    .instr_valid        (instr_valid),
    .fetch_misalign     (fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rvalid;
    logic [28:0] rtag;
    logic [63:0] rdata;
    logic [31:0] pc;
    logic        stall, flush, bpe;
    logic [31:0] e_instr;
    logic        e_vld;
    logic        e_rv16;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  vec_t vt[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic rv, input logic [28:0] tag, input logic [63:0] d,
                              input logic [31:0] p, input logic st, input logic fl, input logic bp,
                              input logic [31:0] ei, input logic ev, input logic e16);
    vec_t v;
    v.rvalid = rv; v.rtag = tag; v.rdata = d; v.pc = p;
    v.stall = st; v.flush = fl; v.bpe = bp;
    v.e_instr = ei; v.e_vld = ev; v.e_rv16 = e16;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [31:0] ei, input logic ev, input logic e16);
    chk({nm, "_instr"},    rv32_instr, ei);
    chk({nm, "_valid"},    {31'b0, instr_valid}, {31'b0, ev});
    chk({nm, "_misalign"}, {31'b0, fetch_misalign}, {31'b0, ~ev});
    chk({nm, "_isrv16"},   {31'b0, isrv16}, {31'b0, e16});
  endtask

  task automatic drive(input logic rv, input logic [28:0] tag, input logic [63:0] d,
                       input logic [31:0] p, input logic st, input logic fl, input logic bp);
    sram_if.isram_rvalid = rv;
    sram_if.isram_rtag   = tag;
    sram_if.isram_rdata  = d;
    pc                   = p;
    fet_stall            = st;
    fet_flush            = fl;
    branch_predict_err   = bp;
  endtask

  initial begin
    drive(1'b0, '0, '0, 32'h0, 1'b0, 1'b0, 1'b0);

`ifdef IFU_FETCH_ALIGN_RVC_EN
    // test 1/2
    vt.push_back(mk(1, 29'd0, 64'h0000_0013_0000_0093, 32'h0, 0,0,0, 32'h0000_0093, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h4, 0,0,0, 32'h0000_0013, 1, 0));
    // test 3: back-to-back crossing
    vt.push_back(mk(1, 29'd0, 64'h4503_0000_0000_0000, 32'h6, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(1, 29'd1, 64'h0000_0000_0000_00a5, 32'h6, 0,0,0, 32'h00a5_4503, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h6, 0,0,0, NOP, 0, 0));
    // test 4: compressed at halfword 3
    vt.push_back(mk(1, 29'd0, 64'h4505_0000_0000_0000, 32'h6, 0,0,0, 32'h0000_4505, 1, 1));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h2, 0,0,0, 32'h0000_0000, 1, 1));
    // test 5: mispredict in CROSS_WAIT, then restart
    vt.push_back(mk(1, 29'd0, 64'h4503_0000_0000_0000, 32'h6, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(1, 29'd1, 64'h0000_0000_0000_00a5, 32'h6, 0,0,1, NOP, 0, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h6, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(1, 29'd0, 64'h4503_0000_0000_0000, 32'h6, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(1, 29'd1, 64'h0000_0000_0000_00a5, 32'h6, 0,0,0, 32'h00a5_4503, 1, 0));
    // test 6: stall around second-line return
    vt.push_back(mk(1, 29'd2, 64'h8003_0000_0000_0000, 32'h16, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h16, 1,0,0, NOP, 0, 0));
    vt.push_back(mk(1, 29'd3, 64'h0000_0000_0000_1234, 32'h16, 1,0,0, 32'h1234_8003, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h16, 1,0,0, 32'h1234_8003, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h16, 0,0,0, 32'h1234_8003, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h16, 0,0,0, NOP, 0, 0));
    // crossing across the top of the address space: tag wraps to 0
    vt.push_back(mk(1, 29'h1FFF_FFFF, 64'h0003_0000_0000_0000, 32'hFFFF_FFFE, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(1, 29'd0, 64'h0000_0000_0000_0040, 32'hFFFF_FFFE, 0,0,0, 32'h0040_0003, 1, 0));
`else
    vt.push_back(mk(1, 29'd0, 64'h0000_0013_0000_0093, 32'h0, 0,0,0, 32'h0000_0093, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h4, 0,0,0, 32'h0000_0013, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h6, 0,0,0, 32'h0000_0013, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h8, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(1, 29'd1, 64'h1111_2222_3333_4444, 32'h8, 0,0,0, 32'h3333_4444, 1, 0));
    vt.push_back(mk(1, 29'd5, 64'hAAAA_BBBB_CCCC_DDDD, 32'hC, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h28, 0,0,0, 32'hCCCC_DDDD, 1, 0));
    vt.push_back(mk(1, 29'd5, 64'hAAAA_BBBB_CCCC_DDDD, 32'h28, 0,1,0, NOP, 0, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h28, 0,0,0, NOP, 0, 0));
    vt.push_back(mk(1, 29'd5, 64'hAAAA_BBBB_CCCC_DDDD, 32'h2C, 0,0,1, NOP, 0, 0));
    vt.push_back(mk(1, 29'd5, 64'h0102_0304_0506_0708, 32'h2C, 1,0,0, 32'h0102_0304, 1, 0));
    vt.push_back(mk(0, 29'd0, 64'h0,                   32'h2C, 1,0,0, 32'h0102_0304, 1, 0));
    // live return beats a matching buffer entry
    vt.push_back(mk(1, 29'd5, 64'h9999_8888_7777_6666, 32'h2C, 0,0,0, 32'h9999_8888, 1, 0));
    vt.push_back(mk(1, 29'h1FFF_FFFF, 64'h0123_4567_89AB_CDEF, 32'hFFFF_FFFC, 0,0,0, 32'h0123_4567, 1, 0));
`endif

    // reset state
    @(negedge clk);
    #2;
    check_out("reset", NOP, 1'b0, 1'b0);
    cpurst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rvalid, vt[i].rtag, vt[i].rdata, vt[i].pc, vt[i].stall, vt[i].flush, vt[i].bpe);
      #2;
      check_out($sformatf("v%0d", i), vt[i].e_instr, vt[i].e_vld, vt[i].e_rv16);
    end

    // Asynchronous reset in the middle of a crossing (or a live word).
    @(negedge clk);
    drive(1'b1, 29'd0, 64'h4503_0000_0000_0000, 32'h6, 1'b0, 1'b0, 1'b0);
    #2;
`ifdef IFU_FETCH_ALIGN_RVC_EN
    check_out("arst_pre", NOP, 1'b0, 1'b0);
`else
    check_out("arst_pre", 32'h4503_0000, 1'b1, 1'b0);
`endif
    @(negedge clk);
    drive(1'b0, 29'd0, 64'h0, 32'h6, 1'b0, 1'b0, 1'b0);
    #1 cpurst_n = 1'b0;
    #1;
    check_out("arst_mid", NOP, 1'b0, 1'b0);
    @(negedge clk);
    cpurst_n = 1'b1;
    drive(1'b1, 29'd1, 64'h0000_0000_0000_00a5, 32'h6, 1'b0, 1'b0, 1'b0);
    #2;
    check_out("arst_post", NOP, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 29'd0, 64'h0, 32'h8, 1'b0, 1'b0, 1'b0);
    #2;
`ifdef IFU_FETCH_ALIGN_RVC_EN
    check_out("arst_buf", 32'h0000_00a5, 1'b1, 1'b1);
`else
    check_out("arst_buf", 32'h0000_00a5, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
